// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision scorer: state encoding, geometry
// constants and the per-enemy overlap test.
package collision_pkg;

  localparam int unsigned NUM_ENEMIES = 4;
  localparam int unsigned POS_W       = 10;

  typedef enum logic [1:0] {
    StPlay  = 2'd0,
    StFlash = 2'd1,
    StOver  = 2'd2
  } state_e;

  // Differences are taken one bit wider than the coordinates so that
  // positions near 0 never alias to positions near 1023.
  function automatic logic overlaps(input logic [POS_W-1:0] px,
                                    input logic [POS_W-1:0] py,
                                    input logic [POS_W-1:0] ex,
                                    input logic [POS_W-1:0] ey,
                                    input logic [POS_W:0]   radius);
    logic [POS_W:0] dx;
    logic [POS_W:0] dy;
    dx = (px >= ex) ? ({1'b0, px} - {1'b0, ex}) : ({1'b0, ex} - {1'b0, px});
    dy = (py >= ey) ? ({1'b0, py} - {1'b0, ey}) : ({1'b0, ey} - {1'b0, py});
    return (dx <= radius) && (dy <= radius);
  endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Bundle of game-side signals between the movement logic and the collision scorer.
interface collision_scorer_if;
  import collision_pkg::*;

  logic                         tick;
  logic [POS_W-1:0]             player_x;
  logic [POS_W-1:0]             player_y;
  logic [NUM_ENEMIES*POS_W-1:0] enemy_x;
  logic [NUM_ENEMIES*POS_W-1:0] enemy_y;
  logic                         hit;
  logic                         flash;
  logic [1:0]                   lives;
  logic                         game_over;
  logic [7:0]                   hit_count;
  logic [15:0]                  score_bcd;

  modport master (
    output tick, player_x, player_y, enemy_x, enemy_y,
    input  hit, flash, lives, game_over, hit_count, score_bcd
  );

  modport slave (
    input  tick, player_x, player_y, enemy_x, enemy_y,
    output hit, flash, lives, game_over, hit_count, score_bcd
  );

endinterface

// File: rtl/collision_scorer_bcd.sv
// Four-digit saturating BCD incrementer used for the survival score.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] value,
  output logic        max_flag
);

  logic [15:0] r_value;
  logic [15:0] w_next;

  always_comb begin
    logic carry;
    w_next = r_value;
    carry  = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r_value[4*d +: 4] == 4'd9) begin
          w_next[4*d +: 4] = 4'd0;
        end else begin
          w_next[4*d +: 4] = r_value[4*d +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  assign max_flag = (r_value == 16'h9999);
  assign value    = r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= 16'h0000;
    end else if (inc && !max_flag) begin
      r_value <= w_next;
    end
  end

endmodule

// File: rtl/collision_scorer.sv
// Player/enemy collision detection with lives, invulnerability flash,
// hit counter and BCD survival score.
module collision_scorer
  import collision_pkg::*;
#(
  parameter int unsigned HIT_RADIUS  = 10,
  parameter int unsigned FLASH_TICKS = 32,
  parameter int unsigned START_LIVES = 3
) (
  input  logic               ClkPort,
  input  logic               Reset,
  collision_scorer_if.slave  bus
);

  localparam int unsigned    CntW      = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [CntW-1:0] FlashLoad = CntW'(FLASH_TICKS - 1);
  localparam logic [POS_W:0]  Radius    = (POS_W + 1)'(HIT_RADIUS);
  localparam logic [1:0]      StartLv   = 2'(START_LIVES);

  logic [NUM_ENEMIES-1:0] w_overlap;
  logic [NUM_ENEMIES-1:0] r_overlap;
  logic                   w_any;
  logic                   r_prev;
  logic                   w_hit_evt;
  logic                   w_score_inc;
  logic                   w_score_max;
  logic [15:0]            w_score;

  state_e                 r_state;
  logic [CntW-1:0]        r_flash_cnt;
  logic [1:0]             r_lives;
  logic                   r_hit;
  logic                   r_flash;
  logic                   r_game_over;
  logic [7:0]             r_hit_count;

  always_comb begin
    w_overlap = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      w_overlap[i] = overlaps(bus.player_x, bus.player_y,
                              bus.enemy_x[POS_W*i +: POS_W],
                              bus.enemy_y[POS_W*i +: POS_W], Radius);
    end
  end

  // Rising edge of "any enemy touching" only; several enemies at once count once.
  assign w_any       = |r_overlap;
  assign w_hit_evt   = w_any && !r_prev && (r_state == StPlay);
  assign w_score_inc = bus.tick && (r_state == StPlay) && !w_score_max;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_overlap   <= '0;
      r_prev      <= 1'b0;
      r_state     <= StPlay;
      r_flash_cnt <= '0;
      r_lives     <= StartLv;
      r_hit       <= 1'b0;
      r_flash     <= 1'b0;
      r_game_over <= 1'b0;
      r_hit_count <= 8'd0;
    end else begin
      r_overlap <= w_overlap;
      r_prev    <= w_any;
      r_hit     <= w_hit_evt;
      if (w_hit_evt && (r_hit_count != 8'hFF)) begin
        r_hit_count <= r_hit_count + 8'd1;
      end
      unique case (r_state)
        StPlay: begin
          if (w_hit_evt) begin
            if (r_lives > 2'd1) begin
              r_lives     <= r_lives - 2'd1;
              r_flash_cnt <= FlashLoad;
              r_state     <= StFlash;
              r_flash     <= 1'b1;
            end else begin
              r_lives     <= 2'd0;
              r_state     <= StOver;
              r_game_over <= 1'b1;
            end
          end
        end
        StFlash: begin
          if (bus.tick) begin
            if (r_flash_cnt == '0) begin
              r_state <= StPlay;
              r_flash <= 1'b0;
            end else begin
              r_flash_cnt <= r_flash_cnt - 1'b1;
            end
          end
        end
        StOver: begin
        end
        default: begin
          r_state <= StPlay;
          r_flash <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter4 u_score (
    .clk      (ClkPort),
    .rst      (Reset),
    .inc      (w_score_inc),
    .value    (w_score),
    .max_flag (w_score_max)
  );

  assign bus.hit       = r_hit;
  assign bus.flash     = r_flash;
  assign bus.lives     = r_lives;
  assign bus.game_over = r_game_over;
  assign bus.hit_count = r_hit_count;
  assign bus.score_bcd = w_score;

endmodule

// File: tb/tb_collision_scorer.sv
// Self-checking bench for collision_scorer against a game-level reference model.
module tb_collision_scorer;
  import collision_pkg::*;

  localparam int R  = 10;
  localparam int FT = 4;
  localparam int SL = 3;
  localparam logic [28:0] RESET_VEC = {1'b0, 1'b0, 2'd3, 1'b0, 8'd0, 16'h0000};

  logic ClkPort = 1'b0;
  logic Reset   = 1'b0;

  collision_scorer_if bus ();

  collision_scorer #(
    .HIT_RADIUS  (R),
    .FLASH_TICKS (FT),
    .START_LIVES (SL)
  ) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #5 ClkPort = ~ClkPort;

  int checks = 0;
  int errors = 0;

  // Game-level model: mode 0 = playing, 1 = invulnerable, 2 = game over.
  int m_mode, m_lives, m_score, m_hits, m_flash_left;
  bit m_hit, m_seen1, m_seen2;
  int px, py;
  int ex[4];
  int ey[4];

  logic [28:0] dut_vec;
  assign dut_vec = {bus.hit, bus.flash, bus.lives, bus.game_over, bus.hit_count, bus.score_bcd};

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [28:0] expected();
    return {m_hit, (m_mode == 1), 2'(m_lives), (m_mode == 2), 8'(m_hits), bcd(m_score)};
  endfunction

  function automatic bit touching();
    for (int i = 0; i < 4; i++) begin
      int dx = (px > ex[i]) ? px - ex[i] : ex[i] - px;
      int dy = (py > ey[i]) ? py - ey[i] : ey[i] - py;
      if (dx <= R && dy <= R) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive();
    bus.player_x = 10'(px);
    bus.player_y = 10'(py);
    for (int i = 0; i < 4; i++) begin
      bus.enemy_x[10*i +: 10] = 10'(ex[i]);
      bus.enemy_y[10*i +: 10] = 10'(ey[i]);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_lives = SL; m_score = 0; m_hits = 0; m_flash_left = 0;
    m_hit = 0; m_seen1 = 0; m_seen2 = 0;
  endtask

  // Advance the model by one clock, then wait for that edge and settle.
  task automatic step();
    bit evt;
    evt = m_seen1 && !m_seen2 && (m_mode == 0);
    if (bus.tick && m_mode == 0 && m_score < 9999) m_score++;
    m_hit = evt;
    if (evt) begin
      if (m_hits < 255) m_hits++;
      if (m_lives > 1) begin
        m_lives--; m_mode = 1; m_flash_left = FT;
      end else begin
        m_lives = 0; m_mode = 2;
      end
    end else if (m_mode == 1 && bus.tick) begin
      m_flash_left--;
      if (m_flash_left == 0) m_mode = 0;
    end
    m_seen2 = m_seen1;
    m_seen1 = touching();
    @(posedge ClkPort);
    #1;
  endtask

  task automatic do_reset();
    bus.tick = 1'b0;
    Reset = 1'b1;
    m_reset();
    @(negedge ClkPort);
    @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  task automatic far_away();
    px = 100; py = 100;
    ex[0] = 200; ey[0] = 200;
    ex[1] = 600; ey[1] = 600;
    ex[2] = 800; ey[2] = 100;
    ex[3] = 100; ey[3] = 900;
    drive();
  endtask

  task automatic test_reset();
    far_away();
    bus.tick = 1'b0;
    Reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
    end
    @(negedge ClkPort);
    Reset = 1'b0;
    step();
    checks++;
    if (dut_vec !== expected()) begin
      errors++; $display("FAIL reset_release: got %h want %h", dut_vec, expected());
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    far_away();
    step(); step();
    ex[0] = 110; ey[0] = 90; drive();
    step();
    checks++;
    if (bus.hit !== 1'b0) begin
      errors++; $display("FAIL hit_latency1: got %b want 0", bus.hit);
    end
    step();
    checks++;
    if ({bus.hit, bus.lives, bus.flash, bus.hit_count} !== {1'b1, 2'd2, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL single_hit: got hit=%b lives=%0d flash=%b cnt=%0d want 1 2 1 1",
               bus.hit, bus.lives, bus.flash, bus.hit_count);
    end
    checks++;
    if (dut_vec !== expected()) begin
      errors++; $display("FAIL single_hit_model: got %h want %h", dut_vec, expected());
    end
    step();
    checks++;
    if (bus.hit !== 1'b0) begin
      errors++; $display("FAIL hit_one_cycle: got %b want 0", bus.hit);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    far_away();
    px = 5; py = 5; ex[0] = 1020; ey[0] = 5; drive();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.hit !== 1'b0 || dut_vec !== expected()) begin
        errors++; $display("FAIL no_wrap: got %h want %h", dut_vec, expected());
      end
    end
    ex[0] = 15; ey[0] = 15; drive();
    step(); step();
    checks++;
    if (bus.hit !== 1'b1 || dut_vec !== expected()) begin
      errors++; $display("FAIL edge_radius_hit: got %h want %h", dut_vec, expected());
    end
    do_reset();
    ex[0] = 16; ey[0] = 5; drive();
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (bus.hit_count !== 8'd0 || dut_vec !== expected()) begin
      errors++; $display("FAIL beyond_radius: got %h want %h", dut_vec, expected());
    end
  endtask

  task automatic test_flash_hold();
    int n;
    do_reset();
    far_away();
    px = 300; py = 300; ex[0] = 305; ey[0] = 295; drive();
    step(); step();
    checks++;
    if (bus.hit !== 1'b1 || dut_vec !== expected()) begin
      errors++; $display("FAIL flash_entry: got %h want %h", dut_vec, expected());
    end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      bus.tick = 1'b1; step();
      bus.tick = 1'b0; step();
      n++;
      checks++;
      if (dut_vec !== expected()) begin
        errors++; $display("FAIL flash_step %0d: got %h want %h", k, dut_vec, expected());
      end
      if (!bus.flash) break;
    end
    checks++;
    if (n != FT) begin
      errors++; $display("FAIL flash_length: got %0d ticks want %0d", n, FT);
    end
    for (int k = 0; k < 5; k++) begin
      bus.tick = 1'(k % 2); step();
    end
    bus.tick = 1'b0;
    checks++;
    if (bus.hit_count !== 8'd1 || dut_vec !== expected()) begin
      errors++; $display("FAIL held_overlap: got %h want %h", dut_vec, expected());
    end
    ex[0] = 500; drive(); step(); step();
    ex[0] = 305; drive(); step(); step();
    checks++;
    if (bus.hit !== 1'b1 || bus.hit_count !== 8'd2 || dut_vec !== expected()) begin
      errors++; $display("FAIL rehit: got %h want %h", dut_vec, expected());
    end
  endtask

  task automatic test_game_over();
    logic [15:0] sc;
    logic [7:0]  hc;
    do_reset();
    far_away();
    for (int h = 0; h < 3; h++) begin
      ex[0] = 105; ey[0] = 105; drive();
      step(); step(); step();
      ex[0] = 200; ey[0] = 200; drive();
      step(); step();
      for (int t = 0; t < FT + 1; t++) begin
        bus.tick = 1'b1; step();
        bus.tick = 1'b0; step();
      end
    end
    checks++;
    if (bus.lives !== 2'd0 || bus.game_over !== 1'b1 || dut_vec !== expected()) begin
      errors++; $display("FAIL game_over: got %h want %h", dut_vec, expected());
    end
    sc = bus.score_bcd;
    hc = bus.hit_count;
    for (int k = 0; k < 20; k++) begin
      bus.tick = 1'($urandom_range(0, 1));
      ex[0] = (k % 3 == 0) ? 200 : 100; ey[0] = ex[0]; drive();
      step();
    end
    bus.tick = 1'b0;
    checks++;
    if (bus.score_bcd !== sc || bus.hit_count !== hc || dut_vec !== expected()) begin
      errors++; $display("FAIL over_frozen: got %h want %h", dut_vec, expected());
    end
  endtask

  task automatic test_score_sat();
    do_reset();
    far_away();
    bus.tick = 1'b1;
    for (int k = 0; k < 10000; k++) step();
    checks++;
    if (bus.score_bcd !== 16'h9999 || dut_vec !== expected()) begin
      errors++; $display("FAIL score_9999: got %h want 9999", bus.score_bcd);
    end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bus.score_bcd !== 16'h9999) begin
      errors++; $display("FAIL score_hold: got %h want 9999", bus.score_bcd);
    end
    do_reset();
    bus.tick = 1'b1;
    for (int k = 0; k < 7; k++) step();
    bus.tick = 1'b0;
    ex[0] = 95; ey[0] = 100; drive();
    step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    checks++;
    if (bus.hit !== 1'b1 || bus.score_bcd !== 16'h0008 || dut_vec !== expected()) begin
      errors++; $display("FAIL tick_with_hit: got %h want %h", dut_vec, expected());
    end
  endtask

  task automatic test_reset_mid_flash();
    do_reset();
    far_away();
    ex[0] = 100; ey[0] = 108; drive();
    step(); step();
    bus.tick = 1'b1; step();
    bus.tick = 1'b0; step();
    checks++;
    if (bus.flash !== 1'b1 || dut_vec !== expected()) begin
      errors++; $display("FAIL pre_reset_flash: got %h want %h", dut_vec, expected());
    end
    #3;
    Reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++; $display("FAIL async_reset: got %h want %h", dut_vec, RESET_VEC);
    end
    @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    far_away();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 7) == 0) begin
        int i = $urandom_range(0, 3);
        ex[i] = px + $urandom_range(0, 36) - 18;
        ey[i] = py + $urandom_range(0, 36) - 18;
        if (ex[i] < 0) ex[i] = 0;
        if (ex[i] > 1023) ex[i] = 1023;
        if (ey[i] < 0) ey[i] = 0;
        if (ey[i] > 1023) ey[i] = 1023;
      end
      drive();
      bus.tick = ($urandom_range(0, 3) == 0);
      if (bus.game_over && $urandom_range(0, 40) == 0) do_reset();
      step();
      checks++;
      if (dut_vec !== expected()) begin
        errors++;
        if (errors < 20)
          $display("FAIL random cycle %0d: got %h want %h", c, dut_vec, expected());
      end
    end
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0;
    m_reset();
    test_reset();
    test_single_hit();
    test_wrap();
    test_flash_hold();
    test_game_over();
    test_score_sat();
    test_reset_mid_flash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
